control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Multicycle FSM controller for the 6-instruction processor. Fetches 16-bit instructions from
//  instruction memory, holds PC and IR, and drives every select/enable of the operational block
//  (register file, 3:1 write mux, ALU) and the data memory. Sits beside opblock in the top level.
// PARAMETERS
//  PC_WIDTH  16  program counter / instruction address width
//  REGBITS    4  register file address width (matches opblock)
//  DADDR      8  data memory address width
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         asynchronous, active-high reset
//  i_data      in   16        instruction memory read data (combinational w.r.t. i_addr)
//  i_addr      out  PC_WIDTH  instruction memory address
//  i_rd        out  1         instruction memory read enable
//  d_addr      out  DADDR     data memory address
//  d_rd, d_wr  out  1 each    data memory read / write enables
//  rf_w_data   out  8         constant for LOADCONST (write-mux input 2)
//  rf_s        out  2         write-mux select: 00 ALU, 01 data mem, 10 constant
//  rf_w_addr   out  REGBITS   register write address;  rf_w_wr out 1 write enable
//  rf_rp_addr  out  REGBITS   port P address;          rf_rp_rd out 1 read enable
//  rf_rq_addr  out  REGBITS   port Q address;          rf_rq_rd out 1 read enable
//  alu_s       out  2         00 bypass, 01 add (P+Q), 10 sub (P-Q)
//  rf_rp_zero  in   1         port P data == 0 (from opblock)
//  halted      out  1         high while FSM is in HALT
// BEHAVIOUR
//  Clock is clk; reset is asynchronous and active-high.
//  Instruction: [15:12] op, [11:8] ra, [7:0] d | {rb[7:4], rc[3:0]} | signed offset.
//  Opcodes: 0 LOAD ra<=D[d]; 1 STORE D[d]<=ra; 2 ADD ra<=rb+rc; 3 LOADC ra<=d;
//   4 SUB ra<=rb-rc; 5 JMPZ if ra==0 PC<=PC+sext(offset)-1; 6..F illegal.
//  Reset: state=INIT, PC=0, IR=0, halted=0; every output enable/select 0 immediately
//   (async), held 0 until reset released. Reset mid-instruction aborts it; no partial write.
//  Default (all states): all enables 0, all selects/addresses 0 unless listed below.
//  States (one clk each):
//   INIT   -> FETCH; PC<=0.
//   FETCH  i_addr=PC, i_rd=1; IR<=i_data; PC<=PC+1 (wraps modulo 2^PC_WIDTH) -> DECODE.
//   DECODE no outputs; op 0..5 -> matching execute state; op 6..F -> HALT.
//   LOAD   d_addr=d, d_rd=1, rf_s=01, rf_w_addr=ra, rf_w_wr=1 -> FETCH.
//   STORE  d_addr=d, d_wr=1, rf_rp_addr=ra, rf_rp_rd=1 -> FETCH.
//   ADD    rf_rp_addr=rb, rf_rq_addr=rc, rp/rq_rd=1, alu_s=01, rf_s=00, w_addr=ra, w_wr=1 -> FETCH.
//   LOADC  rf_w_data=d, rf_s=10, rf_w_addr=ra, rf_w_wr=1 -> FETCH.
//   SUB    as ADD with alu_s=10 -> FETCH.
//   JMPZ   rf_rp_addr=ra, rf_rp_rd=1; if rf_rp_zero: PC<=PC+sext(offset)-1
//          (target = jump address + offset, mod 2^PC_WIDTH) -> FETCH.
//   HALT   halted=1; PC, IR frozen; stays until reset.
//  Latency: LOAD/STORE/ADD/LOADC/SUB/JMPZ = 3 clocks each (FETCH, DECODE, execute).
//  Register/memory writes occur only on the execute-state edge; ra==rb/rc permitted
//   (read old value, write result). Offset 0x00 on taken JMPZ -> PC=jump address-1+... i.e.
//   re-executes the JMPZ (tight loop); 0xFF -> target is previous instruction.
//  Outputs are Moore (state + IR) except JMPZ PC update, which samples rf_rp_zero.
// TESTING
//  1 Reset mid-ADD execute -> all enables 0 same cycle; after release FETCH at i_addr=0.
//  2 LOADC r1,5; LOADC r2,3; SUB r3,r1,r2 -> rf_w_wr on r3 with alu_s=10; opblock r3=2.
//  3 LOADC r0,0 at 0x0; JMPZ r0,+4 at 0x1 -> next FETCH i_addr=0x5; with r0=7 -> i_addr=0x2.
//  4 STORE r1 to d=0x10 then LOAD r4 from d=0x10 -> d_wr then d_rd/rf_s=01; r4==r1.
//  5 Opcode 0x7 at PC=3 -> HALT, halted=1, no further i_rd, PC stays 4 until reset.
//  6 PC=0xFFFF fetch -> PC wraps to 0x0000; JMPZ offset 0xFF taken -> re-target jump-1.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle FSM controller for the 6-instruction processor: holds PC/IR, fetches from
// instruction memory and drives register-file, write-mux, ALU and data-memory controls.
module control_unit #(
  parameter int unsigned PC_WIDTH = 16,
  parameter int unsigned REGBITS  = 4,
  parameter int unsigned DADDR    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         i_data,
  output logic [PC_WIDTH-1:0] i_addr,
  output logic                i_rd,
  output logic [DADDR-1:0]    d_addr,
  output logic                d_rd,
  output logic                d_wr,
  output logic [7:0]          rf_w_data,
  output logic [1:0]          rf_s,
  output logic [REGBITS-1:0]  rf_w_addr,
  output logic                rf_w_wr,
  output logic [REGBITS-1:0]  rf_rp_addr,
  output logic                rf_rp_rd,
  output logic [REGBITS-1:0]  rf_rq_addr,
  output logic                rf_rq_rd,
  output logic [1:0]          alu_s,
  input  logic                rf_rp_zero,
  output logic                halted
);

  localparam int unsigned IR_W = 16;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ADD, S_LOADC, S_SUB, S_JMPZ, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [IR_W-1:0]     ir_q, ir_d;
  logic [PC_WIDTH-1:0] offset_sext;

  logic [PC_WIDTH-1:0] i_addr_q, i_addr_d;
  logic                i_rd_q, i_rd_d;
  logic [DADDR-1:0]    d_addr_q, d_addr_d;
  logic                d_rd_q, d_rd_d;
  logic                d_wr_q, d_wr_d;
  logic [7:0]          rf_w_data_q, rf_w_data_d;
  logic [1:0]          rf_s_q, rf_s_d;
  logic [REGBITS-1:0]  rf_w_addr_q, rf_w_addr_d;
  logic                rf_w_wr_q, rf_w_wr_d;
  logic [REGBITS-1:0]  rf_rp_addr_q, rf_rp_addr_d;
  logic                rf_rp_rd_q, rf_rp_rd_d;
  logic [REGBITS-1:0]  rf_rq_addr_q, rf_rq_addr_d;
  logic                rf_rq_rd_q, rf_rq_rd_d;
  logic [1:0]          alu_s_q, alu_s_d;
  logic                halted_q, halted_d;

  assign offset_sext = {{(PC_WIDTH-8){ir_q[7]}}, ir_q[7:0]};

  // State, PC and IR registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next state, then the controls of that state are decoded one cycle ahead so they can be registered
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    i_addr_d     = '0;
    i_rd_d       = 1'b0;
    d_addr_d     = '0;
    d_rd_d       = 1'b0;
    d_wr_d       = 1'b0;
    rf_w_data_d  = '0;
    rf_s_d       = 2'b00;
    rf_w_addr_d  = '0;
    rf_w_wr_d    = 1'b0;
    rf_rp_addr_d = '0;
    rf_rp_rd_d   = 1'b0;
    rf_rq_addr_d = '0;
    rf_rq_rd_d   = 1'b0;
    alu_s_d      = 2'b00;
    halted_d     = 1'b0;

    case (state_q)
      S_INIT: begin
        state_d = S_FETCH;
        pc_d    = '0;
      end
      S_FETCH: begin
        ir_d    = i_data;
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_q[15:12])
          4'h0:    state_d = S_LOAD;
          4'h1:    state_d = S_STORE;
          4'h2:    state_d = S_ADD;
          4'h3:    state_d = S_LOADC;
          4'h4:    state_d = S_SUB;
          4'h5:    state_d = S_JMPZ;
          default: state_d = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_LOADC, S_SUB: state_d = S_FETCH;
      S_JMPZ: begin
        // PC already points past the JMPZ, so -1 makes the offset relative to the jump itself
        if (rf_rp_zero) pc_d = pc_q + offset_sext - PC_WIDTH'(1);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase

    case (state_d)
      S_FETCH: begin
        i_addr_d = pc_d;
        i_rd_d   = 1'b1;
      end
      S_LOAD: begin
        d_addr_d    = DADDR'(ir_d[7:0]);
        d_rd_d      = 1'b1;
        rf_s_d      = 2'b01;
        rf_w_addr_d = REGBITS'(ir_d[11:8]);
        rf_w_wr_d   = 1'b1;
      end
      S_STORE: begin
        d_addr_d     = DADDR'(ir_d[7:0]);
        d_wr_d       = 1'b1;
        rf_rp_addr_d = REGBITS'(ir_d[11:8]);
        rf_rp_rd_d   = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_rp_addr_d = REGBITS'(ir_d[7:4]);
        rf_rq_addr_d = REGBITS'(ir_d[3:0]);
        rf_rp_rd_d   = 1'b1;
        rf_rq_rd_d   = 1'b1;
        alu_s_d      = (state_d == S_ADD) ? 2'b01 : 2'b10;
        rf_s_d       = 2'b00;
        rf_w_addr_d  = REGBITS'(ir_d[11:8]);
        rf_w_wr_d    = 1'b1;
      end
      S_LOADC: begin
        rf_w_data_d = ir_d[7:0];
        rf_s_d      = 2'b10;
        rf_w_addr_d = REGBITS'(ir_d[11:8]);
        rf_w_wr_d   = 1'b1;
      end
      S_JMPZ: begin
        rf_rp_addr_d = REGBITS'(ir_d[11:8]);
        rf_rp_rd_d   = 1'b1;
      end
      S_HALT:  halted_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; async reset forces every enable and select low immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_addr_q     <= '0;
      i_rd_q       <= 1'b0;
      d_addr_q     <= '0;
      d_rd_q       <= 1'b0;
      d_wr_q       <= 1'b0;
      rf_w_data_q  <= '0;
      rf_s_q       <= 2'b00;
      rf_w_addr_q  <= '0;
      rf_w_wr_q    <= 1'b0;
      rf_rp_addr_q <= '0;
      rf_rp_rd_q   <= 1'b0;
      rf_rq_addr_q <= '0;
      rf_rq_rd_q   <= 1'b0;
      alu_s_q      <= 2'b00;
      halted_q     <= 1'b0;
    end else begin
      i_addr_q     <= i_addr_d;
      i_rd_q       <= i_rd_d;
      d_addr_q     <= d_addr_d;
      d_rd_q       <= d_rd_d;
      d_wr_q       <= d_wr_d;
      rf_w_data_q  <= rf_w_data_d;
      rf_s_q       <= rf_s_d;
      rf_w_addr_q  <= rf_w_addr_d;
      rf_w_wr_q    <= rf_w_wr_d;
      rf_rp_addr_q <= rf_rp_addr_d;
      rf_rp_rd_q   <= rf_rp_rd_d;
      rf_rq_addr_q <= rf_rq_addr_d;
      rf_rq_rd_q   <= rf_rq_rd_d;
      alu_s_q      <= alu_s_d;
      halted_q     <= halted_d;
    end
  end

  assign i_addr     = i_addr_q;
  assign i_rd       = i_rd_q;
  assign d_addr     = d_addr_q;
  assign d_rd       = d_rd_q;
  assign d_wr       = d_wr_q;
  assign rf_w_data  = rf_w_data_q;
  assign rf_s       = rf_s_q;
  assign rf_w_addr  = rf_w_addr_q;
  assign rf_w_wr    = rf_w_wr_q;
  assign rf_rp_addr = rf_rp_addr_q;
  assign rf_rp_rd   = rf_rp_rd_q;
  assign rf_rq_addr = rf_rq_addr_q;
  assign rf_rq_rd   = rf_rq_rd_q;
  assign alu_s      = alu_s_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level model predicts every cycle's controls; a small
// opblock/memory stand-in closes the loop so programs really execute.
module tb_control_unit;

  localparam int P_INIT = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_HALT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_data, i_addr;
  logic        i_rd, d_rd, d_wr, rf_w_wr, rf_rp_rd, rf_rq_rd, rf_rp_zero, halted;
  logic [7:0]  d_addr, rf_w_data;
  logic [1:0]  rf_s, alu_s;
  logic [3:0]  rf_w_addr, rf_rp_addr, rf_rq_addr;

  logic [15:0] imem [65536];
  logic [7:0]  env_rf [16]  = '{default: 8'h00};
  logic [7:0]  env_dm [256] = '{default: 8'h00};
  logic [7:0]  m_rf [16]    = '{default: 8'h00};
  logic [7:0]  m_dm [256]   = '{default: 8'h00};
  logic [7:0]  alu_res;

  int          ph = P_INIT;
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_ir = 16'h0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] fetch_log [$];
  logic [15:0] exp_log [$];
  logic [54:0] act, expv;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(rst), .i_data(i_data), .i_addr(i_addr), .i_rd(i_rd),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .rf_w_data(rf_w_data), .rf_s(rf_s),
    .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr), .rf_rp_addr(rf_rp_addr), .rf_rp_rd(rf_rp_rd),
    .rf_rq_addr(rf_rq_addr), .rf_rq_rd(rf_rq_rd), .alu_s(alu_s), .rf_rp_zero(rf_rp_zero),
    .halted(halted)
  );

  assign act = {i_addr, i_rd, d_addr, d_rd, d_wr, rf_w_data, rf_s, rf_w_addr, rf_w_wr,
                rf_rp_addr, rf_rp_rd, rf_rq_addr, rf_rq_rd, alu_s, halted};

  // Opblock and memories stand-in driven by the DUT controls
  assign i_data     = imem[i_addr];
  assign rf_rp_zero = (env_rf[rf_rp_addr] == 8'h00);
  always_comb begin
    case (alu_s)
      2'b01:   alu_res = env_rf[rf_rp_addr] + env_rf[rf_rq_addr];
      2'b10:   alu_res = env_rf[rf_rp_addr] - env_rf[rf_rq_addr];
      default: alu_res = env_rf[rf_rp_addr];
    endcase
  end
  always @(posedge clk) begin
    if (rf_w_wr) begin
      case (rf_s)
        2'b00:   env_rf[rf_w_addr] <= alu_res;
        2'b01:   env_rf[rf_w_addr] <= env_dm[d_addr];
        2'b10:   env_rf[rf_w_addr] <= rf_w_data;
        default: ;
      endcase
    end
    if (d_wr) env_dm[d_addr] <= env_rf[rf_rp_addr];
  end

  // Instruction-level model: fetch, decode, execute each take one clock
  always @(posedge clk or posedge rst) begin
    logic [3:0] op, ra, rb, rc;
    logic [7:0] d;
    if (rst) begin
      ph = P_INIT; m_pc = 16'h0; m_ir = 16'h0;
    end else begin
      op = m_ir[15:12]; ra = m_ir[11:8]; rb = m_ir[7:4]; rc = m_ir[3:0]; d = m_ir[7:0];
      case (ph)
        P_INIT:   begin ph = P_FETCH; m_pc = 16'h0; end
        P_FETCH:  begin m_ir = imem[m_pc]; m_pc = m_pc + 16'd1; ph = P_DECODE; end
        P_DECODE: ph = (m_ir[15:12] <= 4'd5) ? P_EXEC : P_HALT;
        P_EXEC: begin
          case (op)
            4'h0: m_rf[ra] = m_dm[d];
            4'h1: m_dm[d] = m_rf[ra];
            4'h2: m_rf[ra] = m_rf[rb] + m_rf[rc];
            4'h3: m_rf[ra] = d;
            4'h4: m_rf[ra] = m_rf[rb] - m_rf[rc];
            default: if (m_rf[ra] == 8'h00) m_pc = m_pc + {{8{d[7]}}, d} - 16'd1;
          endcase
          ph = P_FETCH;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [54:0] exp_out(int p, logic [15:0] ir, logic [15:0] pc);
    logic [15:0] ia; logic ird, drd, dwr, ww, prd, qrd, h;
    logic [7:0] da, wd; logic [1:0] s, alu; logic [3:0] wa, pa, qa;
    ia = 16'h0; ird = 0; drd = 0; dwr = 0; ww = 0; prd = 0; qrd = 0; h = 0;
    da = 8'h0; wd = 8'h0; s = 2'b00; alu = 2'b00; wa = 4'h0; pa = 4'h0; qa = 4'h0;
    if (p == P_FETCH) begin
      ia = pc; ird = 1;
    end else if (p == P_HALT) begin
      h = 1;
    end else if (p == P_EXEC) begin
      case (ir[15:12])
        4'h0: begin da = ir[7:0]; drd = 1; s = 2'b01; wa = ir[11:8]; ww = 1; end
        4'h1: begin da = ir[7:0]; dwr = 1; pa = ir[11:8]; prd = 1; end
        4'h2, 4'h4: begin
          pa = ir[7:4]; qa = ir[3:0]; prd = 1; qrd = 1; wa = ir[11:8]; ww = 1;
          alu = (ir[15:12] == 4'h2) ? 2'b01 : 2'b10;
        end
        4'h3: begin wd = ir[7:0]; s = 2'b10; wa = ir[11:8]; ww = 1; end
        default: begin pa = ir[11:8]; prd = 1; end
      endcase
    end
    return {ia, ird, da, drd, dwr, wd, s, wa, ww, pa, prd, qa, qrd, alu, h};
  endfunction

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #2;
    expv = exp_out(ph, m_ir, m_pc);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, act, expv);
    end
    if (i_rd) fetch_log.push_back(i_addr);
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_log(string name);
    check({name, "_len"}, 64'(fetch_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < fetch_log.size(); i++)
      check($sformatf("%s_fetch%0d", name, i), 64'(fetch_log[i]), 64'(exp_log[i]));
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 65536; i++) imem[i] = 16'hF000;
  endtask

  task automatic run_prog(int n);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    fetch_log.delete();
    rst = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    // LOADC/SUB/STORE/LOAD/ADD plus a taken and an untaken JMPZ, then illegal opcode
    clear_imem();
    imem[0] = 16'h3105; imem[1] = 16'h3203; imem[2] = 16'h4312; imem[3] = 16'h1110;
    imem[4] = 16'h0410; imem[5] = 16'h2534; imem[6] = 16'h3000; imem[7] = 16'h5002;
    imem[8] = 16'h36EE; imem[9] = 16'h5504; imem[10] = 16'h7000;
    run_prog(45);
    check("r1", 64'(env_rf[1]), 64'h05);
    check("r3_sub", 64'(env_rf[3]), 64'h02);
    check("r4_load", 64'(env_rf[4]), 64'h05);
    check("r5_add", 64'(env_rf[5]), 64'h07);
    check("r6_skipped", 64'(env_rf[6]), 64'h00);
    check("dmem10_store", 64'(env_dm[16]), 64'h05);
    check("halted_a", 64'(halted), 64'h1);
    for (int i = 0; i < 16; i++) check($sformatf("model_r%0d", i), 64'(env_rf[i]), 64'(m_rf[i]));
    exp_log = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h9, 16'hA};
    check_log("prog_a");

    // Reset while ADD is in its execute cycle: no write, controls drop at once
    clear_imem();
    imem[0] = 16'h3A09; imem[1] = 16'h2A12; imem[2] = 16'h6000;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #3;
      if (rf_w_wr && alu_s == 2'b01 && rf_w_addr == 4'hA) found = 1;
    end
    check("abort_reached_add", 64'(found), 64'h1);
    rst = 1'b1;
    #1;
    check("abort_outputs_zero", 64'(act), 64'h0);
    @(posedge clk); #3;
    check("abort_no_write", 64'(env_rf[10]), 64'h09);
    @(negedge clk);
    fetch_log.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    exp_log = '{16'h0, 16'h1, 16'h2};
    check_log("after_abort");
    check("r10_add", 64'(env_rf[10]), 64'h08);

    // JMPZ taken with +4
    clear_imem();
    imem[0] = 16'h3000; imem[1] = 16'h5004; imem[5] = 16'h6000;
    run_prog(20);
    exp_log = '{16'h0, 16'h1, 16'h5};
    check_log("jmpz_taken");

    // JMPZ not taken
    clear_imem();
    imem[0] = 16'h3007; imem[1] = 16'h5004; imem[2] = 16'h6000;
    run_prog(20);
    exp_log = '{16'h0, 16'h1, 16'h2};
    check_log("jmpz_not_taken");

    // Offset 0xFF lands on the previous instruction
    clear_imem();
    imem[0] = 16'h3000; imem[1] = 16'h5002; imem[2] = 16'h7000; imem[3] = 16'h50FF;
    run_prog(25);
    exp_log = '{16'h0, 16'h1, 16'h3, 16'h2};
    check_log("jmpz_back");

    // Jump back from 0 to 0xFFFF, then PC wraps to 0
    clear_imem();
    imem[0] = 16'h59FF; imem[65535] = 16'h3901; imem[1] = 16'h8000;
    run_prog(25);
    exp_log = '{16'h0, 16'hFFFF, 16'h0, 16'h1};
    check_log("pc_wrap");
    check("r9_wrap", 64'(env_rf[9]), 64'h01);

    // Illegal opcode at PC=3 halts and fetching stops
    clear_imem();
    imem[0] = 16'h3B01; imem[1] = 16'h3C02; imem[2] = 16'h3D03; imem[3] = 16'h7000;
    run_prog(30);
    exp_log = '{16'h0, 16'h1, 16'h2, 16'h3};
    check_log("halt_at3");
    check("halted_at3", 64'(halted), 64'h1);
    check("r13", 64'(env_rf[13]), 64'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
